osd_event_packetizer: RTL and testbench

//  Upstream feeder of the DII flit buffer: captures one debug event (up to MAX_PAYLOAD 16-bit

---
 rtl/dii_package.sv | 10 +
 rtl/osd_pkt_package.sv | 15 +
 rtl/osd_event_packetizer.sv | 141 ++++++++++++++
 tb/tb_osd_event_packetizer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dii_package.sv
// DII flit type shared by every block that drives or consumes the debug interconnect.
package dii_package;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

endpackage

// File: rtl/osd_pkt_package.sv
// Constants and FSM state type for the OSD event packetizer.
package osd_pkt_package;

  localparam logic [1:0] TYPE_EVENT        = 2'b10;
  localparam logic [3:0] TYPE_SUB_OVERFLOW = 4'h5;

  typedef enum logic [2:0] {
    IDLE,
    DEST,
    SRC,
    HDR,
    PAYLOAD
  } state_t;

endpackage

// File: rtl/osd_event_packetizer.sv
// Captures one debug event and serialises it as a DII packet (DEST, SRC, HDR, payload).
// Define OSD_EVENT_OVERFLOW_EN for lossy capture with a drop counter and overflow packets.
module osd_event_packetizer
  import osd_pkt_package::*;
  import dii_package::*;
#(
  parameter int         MAX_PAYLOAD = 8,
  parameter logic [3:0] TYPE_SUB    = 4'h0,
  localparam int        LW          = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                id,
  input  logic [15:0]                dest,
  input  logic                       event_valid,
  output logic                       event_ready,
  input  logic [LW-1:0]              event_len,
  input  logic [16*MAX_PAYLOAD-1:0]  event_data,
  output dii_flit                    flit_out,
  input  logic                       flit_out_ready
);

  state_t        state, state_next;
  logic [15:0]   lat_id, lat_dest;
  logic [LW-1:0] lat_len, cnt, len_clamped;
  logic [15:0]   words [MAX_PAYLOAD];
  logic [15:0]   payload_word;
  logic [3:0]    hdr_sub;
  logic          capture, ovf_start, flit_fire, last_payload;

  assign len_clamped  = (event_len > LW'(MAX_PAYLOAD)) ? LW'(MAX_PAYLOAD) : event_len;
  assign flit_fire    = flit_out.valid && flit_out_ready;
  assign last_payload = (cnt == lat_len - LW'(1));

  always_comb begin
    payload_word = '0;
    for (int i = 0; i < MAX_PAYLOAD; i++) begin
      if (cnt == LW'(i)) payload_word = words[i];
    end
  end

`ifdef OSD_EVENT_OVERFLOW_EN
  logic [15:0] drop_cnt;
  logic        ovf_pkt, drop;

  // Pending drops take priority over a new event; the event offered that cycle is itself dropped.
  assign event_ready = 1'b1;
  assign ovf_start   = (state == IDLE) && (drop_cnt != 16'h0);
  assign capture     = (state == IDLE) && !ovf_start && event_valid;
  assign drop        = event_valid && !capture;
  assign hdr_sub     = ovf_pkt ? TYPE_SUB_OVERFLOW : TYPE_SUB;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      ovf_pkt  <= 1'b0;
    end else begin
      if (ovf_start)    ovf_pkt <= 1'b1;
      else if (capture) ovf_pkt <= 1'b0;
      if (ovf_pkt && state == PAYLOAD && flit_fire)
        drop_cnt <= {15'b0, drop};
      else if (drop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign event_ready = (state == IDLE);
  assign ovf_start   = 1'b0;
  assign capture     = event_ready && event_valid;
  assign hdr_sub     = TYPE_SUB;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_id   <= '0;
      lat_dest <= '0;
      lat_len  <= '0;
      for (int i = 0; i < MAX_PAYLOAD; i++) words[i] <= '0;
    end else if (capture) begin
      lat_id   <= id;
      lat_dest <= dest;
      lat_len  <= len_clamped;
      for (int i = 0; i < MAX_PAYLOAD; i++) words[i] <= event_data[16*i +: 16];
    end
`ifdef OSD_EVENT_OVERFLOW_EN
    else if (ovf_start) begin
      // Overflow packet reuses the payload path with a single word holding the drop count.
      lat_id   <= id;
      lat_dest <= dest;
      lat_len  <= LW'(1);
      words[0] <= drop_cnt;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (state == PAYLOAD && flit_fire)
      cnt <= last_payload ? '0 : cnt + LW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    flit_out   = '0;
    case (state)
      IDLE: begin
        if (capture || ovf_start) state_next = DEST;
      end
      DEST: begin
        flit_out.valid = 1'b1;
        flit_out.data  = lat_dest;
        if (flit_out_ready) state_next = SRC;
      end
      SRC: begin
        flit_out.valid = 1'b1;
        flit_out.data  = lat_id;
        if (flit_out_ready) state_next = HDR;
      end
      HDR: begin
        flit_out.valid = 1'b1;
        flit_out.data  = {TYPE_EVENT, hdr_sub, 10'b0};
        flit_out.last  = (lat_len == '0);
        if (flit_out_ready) state_next = (lat_len == '0) ? IDLE : PAYLOAD;
      end
      PAYLOAD: begin
        flit_out.valid = 1'b1;
        flit_out.data  = payload_word;
        flit_out.last  = last_payload;
        if (flit_out_ready && last_payload) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_osd_event_packetizer.sv
// Self-checking bench for osd_event_packetizer: table of events, flit scoreboard, corner sequences.
// The overflow sequence runs only when OSD_EVENT_OVERFLOW_EN is defined.
module tb_osd_event_packetizer;
  import dii_package::*;

  localparam int MAX_PAYLOAD = 8;
  localparam int LW          = 4;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [15:0]               id = '0;
  logic [15:0]               dest = '0;
  logic                      event_valid = 1'b0;
  logic                      event_ready;
  logic [LW-1:0]             event_len = '0;
  logic [16*MAX_PAYLOAD-1:0] event_data = '0;
  dii_flit                   flit_out;
  logic                      flit_out_ready = 1'b1;

  osd_event_packetizer #(.MAX_PAYLOAD(MAX_PAYLOAD), .TYPE_SUB(4'h0)) dut (
    .clk(clk), .rst(rst), .id(id), .dest(dest),
    .event_valid(event_valid), .event_ready(event_ready),
    .event_len(event_len), .event_data(event_data),
    .flit_out(flit_out), .flit_out_ready(flit_out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]  id;
    logic [15:0]  dest;
    logic [3:0]   len;
    logic [127:0] data;
    logic         stall;
    logic [4:0]   exp_flits;
  } vec_t;

  vec_t         vecs[6];
  logic [16:0]  exp_q[$];
  int           total_count = 0;
  int           pass_count = 0;
  int           fire_count = 0;
  int           ready_mode = 0;
  bit           busy_check = 0;
  bit           prev_stalled = 0;
  dii_flit      prev_flit;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic pushExpected(input vec_t v);
    int n;
    n = (int'(v.len) > MAX_PAYLOAD) ? MAX_PAYLOAD : int'(v.len);
    exp_q.push_back({1'b0, v.dest});
    exp_q.push_back({1'b0, v.id});
    exp_q.push_back({(n == 0), 16'h8000});
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), v.data[16*i +: 16]});
  endtask

  task automatic applyStimulus(input vec_t v);
    int guard = 0;
    while (!event_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("ready_wait", {31'b0, event_ready}, 32'd1);
    id          = v.id;
    dest        = v.dest;
    event_len   = v.len;
    event_data  = v.data;
    event_valid = 1'b1;
    pushExpected(v);
    @(posedge clk); #1;
    event_valid = 1'b0;
    checkOutput("latency", {15'b0, flit_out.valid, flit_out.data}, {15'b0, 1'b1, v.dest});
  endtask

  task automatic waitDrain();
    int guard = 0;
    while ((exp_q.size() != 0 || flit_out.valid) && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("drain", {exp_q.size(), flit_out.valid}, 32'd0);
  endtask

  // Ready pattern generator; toggle mode gives the 1010.. backpressure sequence.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       flit_out_ready = 1'b1;
      1:       flit_out_ready = ~flit_out_ready;
      default: flit_out_ready = 1'b0;
    endcase
  end

  // Scoreboard monitor at the inactive edge: inputs are settled for the coming rising edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stalled = 0;
    end else begin
      if (prev_stalled) checkOutput("stall_hold", {14'b0, flit_out}, {14'b0, prev_flit});
      if (flit_out.valid && flit_out_ready) begin
        fire_count++;
        if (exp_q.size() == 0)
          checkOutput("unexpected_flit", {14'b0, flit_out}, 32'd0);
        else
          checkOutput("flit", {15'b0, flit_out.last, flit_out.data}, {15'b0, exp_q.pop_front()});
      end
`ifndef OSD_EVENT_OVERFLOW_EN
      if (busy_check && flit_out.valid) checkOutput("busy_ready", {31'b0, event_ready}, 32'd0);
`endif
      prev_stalled = flit_out.valid && !flit_out_ready;
      prev_flit    = flit_out;
    end
  end

  initial begin
    logic [127:0] d;
    int           base;
    int           guard;

    vecs[0] = '{16'h0003, 16'h0000, 4'd2, {96'h0, 16'hBEEF, 16'hCAFE}, 1'b0, 5'd5};
    vecs[1] = '{16'h1234, 16'h00AB, 4'd0, 128'h0, 1'b0, 5'd3};
    for (int i = 0; i < 8; i++) d[16*i +: 16] = 16'h1111 * (i + 1);
    vecs[2] = '{16'h0042, 16'h0007, 4'd8, d, 1'b1, 5'd11};
    for (int i = 0; i < 8; i++) d[16*i +: 16] = 16'hA000 + 16'(i);
    vecs[3] = '{16'h0005, 16'h0009, 4'd15, d, 1'b0, 5'd11};
    vecs[4] = '{16'hFFFF, 16'h8001, 4'd1, {112'h0, 16'h5A5A}, 1'b0, 5'd4};
    vecs[5] = '{16'h0011, 16'h0022, 4'd3, {80'h0, 16'h0C0C, 16'h0B0B, 16'h0A0A}, 1'b1, 5'd6};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_flit", {14'b0, flit_out}, 32'd0);
    checkOutput("reset_ready", {31'b0, event_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) begin
      ready_mode = vecs[k].stall ? 1 : 0;
      busy_check = vecs[k].stall;
      base = fire_count;
      applyStimulus(vecs[k]);
      if (!vecs[k].stall) begin
        repeat (int'(vecs[k].exp_flits)) @(posedge clk);
        #1;
        checkOutput("back_to_idle", {30'b0, flit_out.valid, event_ready}, 32'd1);
        checkOutput("queue_empty", exp_q.size(), 32'd0);
      end else begin
        waitDrain();
      end
      busy_check = 0;
      ready_mode = 0;
      checkOutput("flit_count", fire_count - base, {27'b0, vecs[k].exp_flits});
      @(posedge clk); #1;
    end

    // Reset in the middle of a packet, right after the SRC flit is accepted.
    for (int i = 0; i < 4; i++) d[16*i +: 16] = 16'hD000 + 16'(i);
    base = fire_count;
    applyStimulus('{16'h0101, 16'h0202, 4'd4, d, 1'b0, 5'd7});
    guard = 0;
    while (fire_count < base + 2 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("src_reached", fire_count - base, 32'd2);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    checkOutput("abort_valid", {31'b0, flit_out.valid}, 32'd0);
    checkOutput("abort_ready", {31'b0, event_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    base = fire_count;
    applyStimulus('{16'h0303, 16'h0404, 4'd1, {112'h0, 16'h7777}, 1'b0, 5'd4});
    waitDrain();
    checkOutput("post_abort_count", fire_count - base, 32'd4);

`ifdef OSD_EVENT_OVERFLOW_EN
    // Three events offered while busy are dropped and reported in an overflow packet.
    id          = 16'h0003;
    dest        = 16'h0000;
    event_len   = 4'd1;
    event_data  = {112'h0, 16'h1234};
    event_valid = 1'b1;
    exp_q.push_back({1'b0, 16'h0000});
    exp_q.push_back({1'b0, 16'h0003});
    exp_q.push_back({1'b0, 16'h8000});
    exp_q.push_back({1'b1, 16'h1234});
    exp_q.push_back({1'b0, 16'h0000});
    exp_q.push_back({1'b0, 16'h0003});
    exp_q.push_back({1'b0, 16'h9400});
    exp_q.push_back({1'b1, 16'h0003});
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    event_valid = 1'b0;
    waitDrain();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ovf_cleared", {31'b0, flit_out.valid}, 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
